tdpram_aclkd_sclk: RTL and testbench



---
 rtl/tdpram_aclkd_sclk_pkg.sv | 11 +
 rtl/tdpram_byte_lane.sv | 32 +++
 rtl/tdpram_aclkd_sclk.sv | 75 +++++++
 tb/tb_tdpram_aclkd_sclk.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tdpram_aclkd_sclk_pkg.sv
// Shared byte-lane geometry for the L2 data-array RAM.
package tdpram_aclkd_sclk_pkg;

  localparam int unsigned BYTE_W = 8;

  // Number of byte lanes in a word of width dw.
  function automatic int unsigned num_lanes(input int unsigned dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/tdpram_byte_lane.sv
// One byte-wide, 2^AW-deep dual-port storage lane with a write enable per port.
// The read data is combinational. The parent registers it, so reads return the contents from before the write (read-first).
module tdpram_byte_lane
  import tdpram_aclkd_sclk_pkg::*;
#(
  parameter int unsigned AW = 13
) (
  input  logic              clk_i,
  input  logic              we_a_i,
  input  logic [AW-1:0]     addr_a_i,
  input  logic [BYTE_W-1:0] din_a_i,
  output logic [BYTE_W-1:0] rdata_a_c,
  input  logic              we_b_i,
  input  logic [AW-1:0]     addr_b_i,
  input  logic [BYTE_W-1:0] din_b_i,
  output logic [BYTE_W-1:0] rdata_b_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [BYTE_W-1:0] mem_q [DEPTH];

  // Port B is written last, so it wins if both enables target one address.
  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[addr_a_i] <= din_a_i;
    if (we_b_i) mem_q[addr_b_i] <= din_b_i;
  end

  assign rdata_a_c = mem_q[addr_a_i];
  assign rdata_b_c = mem_q[addr_b_i];

endmodule

// File: rtl/tdpram_aclkd_sclk.sv
// True dual-port byte-writable RAM for the L2 data array.
// Port A handles refill and write-back traffic; port B handles CPU hits. Both ports have registered 1-cycle reads.
module tdpram_aclkd_sclk
  import tdpram_aclkd_sclk_pkg::*;
#(
  parameter int unsigned L2_CH_AW = 13,
  parameter int unsigned L2_CH_DW = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_a,
  input  logic [L2_CH_AW-1:0]        addr_a,
  input  logic [L2_CH_DW/BYTE_W-1:0] we_a,
  input  logic [L2_CH_DW-1:0]        din_a,
  output logic [L2_CH_DW-1:0]        dout_a,
  input  logic                       en_b,
  input  logic [L2_CH_AW-1:0]        addr_b,
  input  logic [L2_CH_DW/BYTE_W-1:0] we_b,
  input  logic [L2_CH_DW-1:0]        din_b,
  output logic [L2_CH_DW-1:0]        dout_b
);

  localparam int unsigned NB = num_lanes(L2_CH_DW);

  if ((L2_CH_DW % BYTE_W) != 0) begin : g_dw_chk
    $fatal(1, "tdpram_aclkd_sclk: L2_CH_DW must be a multiple of 8");
  end

  logic [NB-1:0]       wr_a_c;
  logic [NB-1:0]       wr_b_c;
  logic [L2_CH_DW-1:0] rd_a_c;
  logic [L2_CH_DW-1:0] rd_b_c;
  logic [L2_CH_DW-1:0] dout_a_q;
  logic [L2_CH_DW-1:0] dout_b_q;

  // Lane write strobes: reset blocks writes; B owns lanes both ports hit.
  always_comb begin
    wr_a_c = '0;
    wr_b_c = '0;
    if (rst_n) begin
      if (en_a) wr_a_c = we_a;
      if (en_b) wr_b_c = we_b;
    end
    if (addr_a == addr_b) wr_a_c = wr_a_c & ~wr_b_c;
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    tdpram_byte_lane #(.AW(L2_CH_AW)) u_lane (
      .clk_i     (clk),
      .we_a_i    (wr_a_c[i]),
      .addr_a_i  (addr_a),
      .din_a_i   (din_a[i*BYTE_W +: BYTE_W]),
      .rdata_a_c (rd_a_c[i*BYTE_W +: BYTE_W]),
      .we_b_i    (wr_b_c[i]),
      .addr_b_i  (addr_b),
      .din_b_i   (din_b[i*BYTE_W +: BYTE_W]),
      .rdata_b_c (rd_b_c[i*BYTE_W +: BYTE_W])
    );
  end

  // Output registers: clear on reset, load on enable, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_a_q <= '0;
      dout_b_q <= '0;
    end else begin
      if (en_a) dout_a_q <= rd_a_c;
      if (en_b) dout_b_q <= rd_b_c;
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;

endmodule

// File: tb/tb_tdpram_aclkd_sclk.sv
// Scoreboard bench for tdpram_aclkd_sclk: a word-level memory model predicts each cycle's dout_a/dout_b.
module tb_tdpram_aclkd_sclk;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic        chk;
    logic [31:0] v;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_a, en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [3:0]    we_a, we_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [int];
  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        exp_a, exp_b;

  always #5 clk = ~clk;

  tdpram_aclkd_sclk #(.L2_CH_AW(AW), .L2_CH_DW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_a   (en_a),
    .addr_a (addr_a),
    .we_a   (we_a),
    .din_a  (din_a),
    .dout_a (dout_a),
    .en_b   (en_b),
    .addr_b (addr_b),
    .we_b   (we_b),
    .din_b  (din_b),
    .dout_b (dout_b)
  );

  function automatic exp_t model_read(input int a);
    exp_t e;
    e.chk = mem.exists(a) && !$isunknown(mem[a]);
    e.v   = mem.exists(a) ? mem[a] : 32'h0;
    return e;
  endfunction

  // Apply one cycle of stimulus and predict both outputs after the next edge.
  task automatic drive(input logic r,
                       input logic ea, input int aa, input logic [3:0] wa, input logic [31:0] da,
                       input logic eb, input int ab, input logic [3:0] wb, input logic [31:0] db);
    logic [31:0] w;
    @(negedge clk);
    rst_n  = r;
    en_a   = ea; addr_a = AW'(aa); we_a = wa; din_a = da;
    en_b   = eb; addr_b = AW'(ab); we_b = wb; din_b = db;
    if (!r) begin
      exp_a = '{chk: 1'b1, v: 32'h0};
      exp_b = '{chk: 1'b1, v: 32'h0};
    end else begin
      if (ea) exp_a = model_read(aa);
      if (eb) exp_b = model_read(ab);
      if (ea && wa != 4'h0) begin
        w = mem.exists(aa) ? mem[aa] : 32'hx;
        for (int i = 0; i < 4; i++) if (wa[i]) w[i*8 +: 8] = da[i*8 +: 8];
        mem[aa] = w;
      end
      if (eb && wb != 4'h0) begin
        w = mem.exists(ab) ? mem[ab] : 32'hx;
        for (int i = 0; i < 4; i++) if (wb[i]) w[i*8 +: 8] = db[i*8 +: 8];
        mem[ab] = w;
      end
    end
    qa.push_back(exp_a);
    qb.push_back(exp_b);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: each edge updates (or holds) both outputs; compare against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        if (e.chk) begin
          total++;
          if (dout_a !== e.v) begin
            bad++;
            $display("FAIL sb_dout_a: got %h expected %h", dout_a, e.v);
          end
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        if (e.chk) begin
          total++;
          if (dout_b !== e.v) begin
            bad++;
            $display("FAIL sb_dout_b: got %h expected %h", dout_b, e.v);
          end
        end
      end
    end
  end

  initial begin
    int ra, rb;
    exp_a = '{chk: 1'b0, v: 32'h0};
    exp_b = '{chk: 1'b0, v: 32'h0};
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    addr_a = '0; addr_b = '0; we_a = '0; we_b = '0; din_a = '0; din_b = '0;

    drive(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
    drive(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);

    // Fill addresses 0..31 and the top word with known data.
    for (int i = 0; i < 32; i++)
      drive(1, 1, i, 4'hF, (i == 5) ? 32'hCAFE0005 : (i == 7) ? 32'h0 : $urandom,
            (i == 0), (1 << AW) - 1, 4'hF, 32'h5A5A_0FFF);

    // Byte mask.
    drive(1, 1, 'h10, 4'hF, 32'h11223344, 0, 0, 4'h0, 0);
    drive(1, 1, 'h10, 4'b0011, 32'hAABBCCDD, 0, 0, 4'h0, 0);
    drive(1, 0, 0, 4'h0, 0, 1, 'h10, 4'h0, 0);
    after_edge();
    chk("byte_mask", dout_b, 32'h1122CCDD);

    // Read-first on the same port.
    drive(1, 0, 0, 4'h0, 0, 1, 7, 4'hF, 32'hDEADBEEF);
    after_edge();
    chk("read_first_old", dout_b, 32'h0);
    drive(1, 0, 0, 4'h0, 0, 1, 7, 4'h0, 0);
    after_edge();
    chk("read_first_new", dout_b, 32'hDEADBEEF);

    // Cross-port: A writes while B reads the same address.
    drive(1, 1, 3, 4'hF, 32'h0BAD_0003, 0, 0, 4'h0, 0);
    drive(1, 1, 3, 4'hF, 32'h12345678, 1, 3, 4'h0, 32'hFFFFFFFF);
    after_edge();
    chk("cross_old", dout_b, 32'h0BAD_0003);
    drive(1, 0, 0, 4'h0, 0, 1, 3, 4'h0, 0);
    after_edge();
    chk("cross_new", dout_b, 32'h12345678);

    // Write-write collision.
    drive(1, 1, 9, 4'hF, 32'hAAAAAAAA, 1, 9, 4'b0101, 32'hBBBBBBBB);
    drive(1, 1, 9, 4'h0, 0, 0, 0, 4'h0, 0);
    after_edge();
    chk("ww_merge", dout_a, 32'hAABBAABB);

    // Hold on A while B streams reads.
    drive(1, 1, 'h10, 4'h0, 0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 'h10 + i, 4'hF, $urandom, 1, i, 4'h0, 0);
      after_edge();
      chk("hold_a", dout_a, 32'h1122CCDD);
    end

    // Reset with enables and full write masks: outputs clear, memory is untouched.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 5, 4'hF, $urandom, 1, 5, 4'hF, $urandom);
      after_edge();
      chk("rst_dout_a", dout_a, 32'h0);
      chk("rst_dout_b", dout_b, 32'h0);
    end
    drive(1, 1, 5, 4'h0, 0, 1, 5, 4'h0, 0);
    after_edge();
    chk("rst_mem_a", dout_a, 32'hCAFE0005);
    chk("rst_mem_b", dout_b, 32'hCAFE0005);

    // Random traffic over a small address pool so collisions are frequent.
    for (int n = 0; n < 400; n++) begin
      ra = ($urandom_range(0, 9) == 0) ? (1 << AW) - 1 : $urandom_range(0, 7);
      rb = ($urandom_range(0, 9) == 0) ? (1 << AW) - 1 : $urandom_range(0, 7);
      drive(($urandom_range(0, 29) != 0),
            $urandom_range(0, 3) != 0, ra, 4'($urandom), $urandom,
            $urandom_range(0, 3) != 0, rb, 4'($urandom), $urandom);
    end

    drive(1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
    after_edge();
    after_edge();
    total++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
